// File: rtl/fetch_pkg.sv
// fetch_pkg: shared instruction width, RV32 opcode constants and fetch FSM states
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD} state_t;
endpackage

// File: rtl/fetch_opcode_check.sv
// fetch_opcode_check: flags whether an opcode is one the control unit decodes
// Ports: i_opcode - instruction bits [6:0]; o_legal - 1 for R/I-ALU/load/store/branch
module fetch_opcode_check
    import fetch_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic       o_legal
);
    assign o_legal = i_opcode inside {OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH};
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding RV32 instruction fetch with redirect and one-entry output buffer
// Ports: clk/rst (sync, active-high); o_mem_req/o_mem_addr/i_mem_gnt/i_mem_rvalid/i_mem_rdata - memory port;
// i_redirect_valid/i_redirect_pc - branch redirect; o_out_valid/i_out_ready/o_out_instr/o_out_pc/o_out_opcode - decoder side.
// Define FETCH_ILLEGAL_CHECK_EN to add o_out_illegal (unsupported opcode while o_out_valid).
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               o_mem_req,
    output logic [ADDR_W-1:0]  o_mem_addr,
    input  logic               i_mem_gnt,
    input  logic               i_mem_rvalid,
    input  logic [INSTR_W-1:0] i_mem_rdata,
    input  logic               i_redirect_valid,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [INSTR_W-1:0] o_out_instr,
    output logic [ADDR_W-1:0]  o_out_pc,
`ifdef FETCH_ILLEGAL_CHECK_EN
    output logic               o_out_illegal,
`endif
    output logic [6:0]         o_out_opcode
);
    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_pc, r_out_pc;
    logic [INSTR_W-1:0]  r_instr;
    logic                r_drop, w_drop_nxt, w_capture;
    // A response is kept only if it was not already doomed and no redirect arrives with it
    assign w_capture = (r_state == ST_WAIT) && i_mem_rvalid && !r_drop && !i_redirect_valid;
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (i_mem_gnt) begin
                    w_state_nxt = ST_WAIT;
                    w_drop_nxt  = i_redirect_valid;
                end
            end
            ST_WAIT: begin
                if (i_mem_rvalid) begin
                    w_state_nxt = w_capture ? ST_HOLD : ST_REQ;
                    w_drop_nxt  = 1'b0;
                end else begin
                    w_drop_nxt  = r_drop | i_redirect_valid;
                end
            end
            ST_HOLD: w_state_nxt = (i_redirect_valid || i_out_ready) ? ST_REQ : ST_HOLD;
            default: w_state_nxt = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_drop   <= 1'b0;
            r_instr  <= '0;
            r_out_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            r_pc    <= i_redirect_valid ? {i_redirect_pc[ADDR_W-1:2], 2'b00}
                     : w_capture        ? r_pc + ADDR_W'(4)
                     :                    r_pc;
            if (w_capture) begin
                r_instr  <= i_mem_rdata;
                r_out_pc <= r_pc;
            end
        end
    end
    assign o_mem_req    = (r_state == ST_REQ);
    assign o_mem_addr   = r_pc;
    assign o_out_valid  = (r_state == ST_HOLD);
    assign o_out_instr  = r_instr;
    assign o_out_pc     = r_out_pc;
    assign o_out_opcode = r_instr[6:0];
`ifdef FETCH_ILLEGAL_CHECK_EN
    logic w_legal;
    fetch_opcode_check u_opcode_check (
        .i_opcode (r_instr[6:0]),
        .o_legal  (w_legal)
    );
    assign o_out_illegal = o_out_valid & ~w_legal;
`endif
endmodule
